// File: rtl/mistral_div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package mistral_div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 27;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/mistral_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module mistral_div_step #(
    parameter int WIDTH = 27
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s;

    // The shifted-out MSB is an implicit carry: when set, the shifted value always exceeds the divisor.
    always_comb begin
        shifted_s = {rem_i[WIDTH-2:0], bit_i};
        diff_s    = shifted_s - div_i;
        ge_s      = rem_i[WIDTH-1] | (shifted_s >= div_i);
        q_o       = ge_s;
        if (ge_s) begin
            rem_o = diff_s;
        end else begin
            rem_o = shifted_s;
        end
    end

endmodule

// File: rtl/mistral_seq_div.sv
// Sequential signed/unsigned divider: magnitude restoring core, one bit per cycle,
// sign fix-up in a dedicated cycle, result held until the consumer accepts it.
module mistral_seq_div
    import mistral_div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH_DEFAULT,
    parameter bit SIGNED = 1'b1
) (
    input  logic             CLK,
    input  logic             ARST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DIV_ZERO
);

    localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        if (neg) begin
            return (~x) + W_ONE;
        end else begin
            return x;
        end
    endfunction

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] q_res_q, q_res_d;
    logic [WIDTH-1:0] r_res_q, r_res_d;
    logic             dz_res_q, dz_res_d;

    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] step_rem_s;
    logic             step_q_s;

    assign a_neg_s = SIGNED & A[WIDTH-1];
    assign b_neg_s = SIGNED & B[WIDTH-1];

    // quo_q starts as the dividend magnitude; its MSB feeds each step while quotient bits shift in at the LSB.
    mistral_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .bit_i (quo_q[WIDTH-1]),
        .div_i (dvs_q),
        .rem_o (step_rem_s),
        .q_o   (step_q_s)
    );

    // Next-state and datapath updates for the IDLE/CALC/FIX/DONE sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        q_res_d  = q_res_q;
        r_res_d  = r_res_q;
        dz_res_d = dz_res_q;
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    state_d = ST_CALC;
                    cnt_d   = CNT_LAST;
                    rem_d   = W_ZERO;
                    quo_d   = cond_neg(A, a_neg_s);
                    dvs_d   = cond_neg(B, b_neg_s);
                    qneg_d  = a_neg_s ^ b_neg_s;
                    rneg_d  = a_neg_s;
                    dz_d    = (B == W_ZERO);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                rem_d = step_rem_s;
                quo_d = {quo_q[WIDTH-2:0], step_q_s};
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_FIX: begin
                // Divide-by-zero reports all ones regardless of sign; remainder fix-up restores A.
                if (dz_q) begin
                    q_res_d = W_ONES;
                end else begin
                    q_res_d = cond_neg(quo_q, qneg_q);
                end
                r_res_d  = cond_neg(rem_q, rneg_q);
                dz_res_d = dz_q;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (OUT_READY) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            rem_q    <= W_ZERO;
            quo_q    <= W_ZERO;
            dvs_q    <= W_ZERO;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            q_res_q  <= W_ZERO;
            r_res_q  <= W_ZERO;
            dz_res_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            q_res_q  <= q_res_d;
            r_res_q  <= r_res_d;
            dz_res_q <= dz_res_d;
        end
    end

    assign IN_READY  = (state_q == ST_IDLE);
    assign OUT_VALID = (state_q == ST_DONE);
    assign Q         = q_res_q;
    assign R         = r_res_q;
    assign DIV_ZERO  = dz_res_q;

endmodule

// File: tb/tb_mistral_seq_div.sv
// Directed bench: an unsigned and a signed divider share stimulus; each task checks its own scenario.
module tb_mistral_seq_div;

    localparam int W = 27;

    logic         CLK = 1'b0;
    logic         ARST;
    logic         IN_VALID;
    logic         OUT_READY;
    logic [W-1:0] A;
    logic [W-1:0] B;

    logic         u_ir, u_ov, u_dz, s_ir, s_ov, s_dz;
    logic [W-1:0] u_q, u_r, s_q, s_r;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mistral_seq_div #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
        .CLK(CLK), .ARST(ARST), .IN_VALID(IN_VALID), .IN_READY(u_ir), .A(A), .B(B),
        .OUT_VALID(u_ov), .OUT_READY(OUT_READY), .Q(u_q), .R(u_r), .DIV_ZERO(u_dz)
    );

    mistral_seq_div #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
        .CLK(CLK), .ARST(ARST), .IN_VALID(IN_VALID), .IN_READY(s_ir), .A(A), .B(B),
        .OUT_VALID(s_ov), .OUT_READY(OUT_READY), .Q(s_q), .R(s_r), .DIV_ZERO(s_dz)
    );

    // Accept one operation, scramble the operands afterwards, wait (bounded) for both results.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lu, output int ls);
        int lat;
        A = a;
        B = b;
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        A = ~a;
        B = b ^ 27'h5A5A5A5;
        lat = 1;
        lu = 0;
        ls = 0;
        while (!(u_ov && s_ov) && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
            if (u_ov && lu == 0) lu = lat;
            if (s_ov && ls == 0) ls = lat;
        end
        if (lu == 0) lu = 999;
        if (ls == 0) ls = 999;
    endtask

    task automatic release_out();
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({u_ir, u_ov, u_dz, u_q, u_r} !== {1'b1, 1'b0, 1'b0, 27'd0, 27'd0}) begin
            errors++;
            $display("FAIL reset_unsigned: ir=%b ov=%b dz=%b q=%h r=%h want ir=1 ov=0 dz=0 q=0 r=0", u_ir, u_ov, u_dz, u_q, u_r);
        end
        checks++;
        if ({s_ir, s_ov, s_dz, s_q, s_r} !== {1'b1, 1'b0, 1'b0, 27'd0, 27'd0}) begin
            errors++;
            $display("FAIL reset_signed: ir=%b ov=%b dz=%b q=%h r=%h want ir=1 ov=0 dz=0 q=0 r=0", s_ir, s_ov, s_dz, s_q, s_r);
        end
    endtask

    task automatic test_unsigned();
        int lu, ls;
        run_op(27'd100, 27'd7, lu, ls);
        checks++;
        if ({u_q, u_r, u_dz} !== {27'd14, 27'd2, 1'b0}) begin
            errors++;
            $display("FAIL unsigned_100_7: q=%0d r=%0d dz=%b want q=14 r=2 dz=0", u_q, u_r, u_dz);
        end
        checks++;
        if (lu !== 29) begin
            errors++;
            $display("FAIL latency_unsigned: got %0d want 29", lu);
        end
        checks++;
        if ({s_q, s_r, s_dz} !== {27'd14, 27'd2, 1'b0}) begin
            errors++;
            $display("FAIL signed_100_7: q=%0d r=%0d dz=%b want q=14 r=2 dz=0", s_q, s_r, s_dz);
        end
        checks++;
        if (ls !== 29) begin
            errors++;
            $display("FAIL latency_signed: got %0d want 29", ls);
        end
        release_out();
    endtask

    task automatic test_signed();
        logic [W-1:0] ta [4], tb [4], tsq [4], tsr [4], tuq [4], tur [4];
        int lu, ls;
        ta  = '{27'h7FFFFF9, 27'd7,       27'h7FFFFF9, 27'h4000000};
        tb  = '{27'd2,       27'h7FFFFFE, 27'h7FFFFFE, 27'h7FFFFFF};
        tsq = '{27'h7FFFFFD, 27'h7FFFFFD, 27'd3,       27'h4000000};
        tsr = '{27'h7FFFFFF, 27'd1,       27'h7FFFFFF, 27'd0};
        tuq = '{27'h3FFFFFC, 27'd0,       27'd0,       27'd0};
        tur = '{27'd1,       27'd7,       27'h7FFFFF9, 27'h4000000};
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], lu, ls);
            checks++;
            if ({s_q, s_r, s_dz} !== {tsq[i], tsr[i], 1'b0}) begin
                errors++;
                $display("FAIL signed_vec%0d: q=%h r=%h dz=%b want q=%h r=%h dz=0", i, s_q, s_r, s_dz, tsq[i], tsr[i]);
            end
            checks++;
            if ({u_q, u_r, u_dz} !== {tuq[i], tur[i], 1'b0}) begin
                errors++;
                $display("FAIL unsigned_vec%0d: q=%h r=%h dz=%b want q=%h r=%h dz=0", i, u_q, u_r, u_dz, tuq[i], tur[i]);
            end
            release_out();
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] ta [2];
        int lu, ls;
        ta = '{27'd5, 27'h7FFFFFB};
        for (int i = 0; i < 2; i++) begin
            run_op(ta[i], 27'd0, lu, ls);
            checks++;
            if ({u_q, u_r, u_dz} !== {27'h7FFFFFF, ta[i], 1'b1}) begin
                errors++;
                $display("FAIL divzero_unsigned%0d: q=%h r=%h dz=%b want q=7ffffff r=%h dz=1", i, u_q, u_r, u_dz, ta[i]);
            end
            checks++;
            if ({s_q, s_r, s_dz} !== {27'h7FFFFFF, ta[i], 1'b1}) begin
                errors++;
                $display("FAIL divzero_signed%0d: q=%h r=%h dz=%b want q=7ffffff r=%h dz=1", i, s_q, s_r, s_dz, ta[i]);
            end
            checks++;
            if (lu !== 29 || ls !== 29) begin
                errors++;
                $display("FAIL divzero_latency%0d: got u=%0d s=%0d want 29", i, lu, ls);
            end
            release_out();
        end
    endtask

    task automatic test_hold_back_to_back();
        logic [W-1:0] a, b, euq, eur, esq, esr;
        logic signed [W-1:0] sa, sb;
        int lu, ls;
        run_op(27'd1000, 27'd33, lu, ls);
        // Result must hold while the consumer stalls, and IN_VALID during DONE must be ignored.
        for (int i = 0; i < 10; i++) begin
            IN_VALID = 1'b1;
            A = 27'd55;
            B = 27'd5;
            @(posedge CLK); #1;
            checks++;
            if ({u_ov, u_ir, u_q, u_r, u_dz, s_ov, s_ir, s_q, s_r, s_dz} !==
                {1'b1, 1'b0, 27'd30, 27'd10, 1'b0, 1'b1, 1'b0, 27'd30, 27'd10, 1'b0}) begin
                errors++;
                $display("FAIL hold_cycle%0d: u ov=%b ir=%b q=%0d r=%0d s ov=%b ir=%b q=%0d r=%0d want ov=1 ir=0 q=30 r=10",
                         i, u_ov, u_ir, u_q, u_r, s_ov, s_ir, s_q, s_r);
            end
        end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        IN_VALID = 1'b0;
        checks++;
        if ({u_ir, u_ov, s_ir, s_ov} !== 4'b1010) begin
            errors++;
            $display("FAIL release_to_idle: u ir=%b ov=%b s ir=%b ov=%b want ir=1 ov=0", u_ir, u_ov, s_ir, s_ov);
        end
        for (int i = 0; i < 4; i++) begin
            a = 27'($urandom);
            b = 27'($urandom) >> $urandom_range(0, 20);
            if (b == 27'd0 || b == 27'h7FFFFFF) b = 27'd3;
            euq = a / b;
            eur = a % b;
            sa = a;
            sb = b;
            esq = sa / sb;
            esr = sa % sb;
            run_op(a, b, lu, ls);
            checks++;
            if ({u_q, u_r, u_dz} !== {euq, eur, 1'b0} || lu !== 29) begin
                errors++;
                $display("FAIL b2b_unsigned%0d: a=%h b=%h q=%h r=%h lat=%0d want q=%h r=%h lat=29", i, a, b, u_q, u_r, lu, euq, eur);
            end
            checks++;
            if ({s_q, s_r, s_dz} !== {esq, esr, 1'b0} || ls !== 29) begin
                errors++;
                $display("FAIL b2b_signed%0d: a=%h b=%h q=%h r=%h lat=%0d want q=%h r=%h lat=29", i, a, b, s_q, s_r, ls, esq, esr);
            end
            release_out();
        end
    endtask

    task automatic test_arst_mid();
        int seen;
        int lu, ls;
        A = 27'd999;
        B = 27'd3;
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (10) @(posedge CLK);
        #4;
        ARST = 1'b1;
        #1;
        checks++;
        if ({u_ir, u_ov, u_q, u_r, u_dz, s_ir, s_ov, s_q, s_r, s_dz} !==
            {1'b1, 1'b0, 27'd0, 27'd0, 1'b0, 1'b1, 1'b0, 27'd0, 27'd0, 1'b0}) begin
            errors++;
            $display("FAIL arst_immediate: u ir=%b ov=%b q=%h r=%h s ir=%b ov=%b q=%h r=%h want ir=1 ov=0 q=0 r=0",
                     u_ir, u_ov, u_q, u_r, s_ir, s_ov, s_q, s_r);
        end
        #2;
        ARST = 1'b0;
        seen = 0;
        repeat (35) begin
            @(posedge CLK); #1;
            if (u_ov || s_ov) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL arst_no_result: got %0d valid cycles want 0", seen);
        end
        run_op(27'd100, 27'd7, lu, ls);
        checks++;
        if ({u_q, u_r, s_q, s_r} !== {27'd14, 27'd2, 27'd14, 27'd2} || lu !== 29 || ls !== 29) begin
            errors++;
            $display("FAIL after_arst_100_7: u q=%0d r=%0d s q=%0d r=%0d lat=%0d/%0d want q=14 r=2 lat=29",
                     u_q, u_r, s_q, s_r, lu, ls);
        end
        release_out();
    endtask

    initial begin
        ARST = 1'b1;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        A = 27'd0;
        B = 27'd0;
        #12;
        test_reset();
        #1;
        ARST = 1'b0;
        test_unsigned();
        test_signed();
        test_div_zero();
        test_hold_back_to_back();
        test_arst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
